hazard_unit: RTL and testbench
==============================

# hazard_unit

Central pipeline controller that produces the four latch-state controls (fd, de, em, mw) and the PC enable for the five-stage pipeline. It resolves instruction-cache misses, data-cache waits, load-use hazards, taken branches/jumps and halt into per-latch ENABLE/STALL/FLUSH commands. It also buffers a fetched instruction that arrives while fetch cannot advance. It sits directly upstream of the pipeline latches and drives their state inputs.

## Interface
Parameters: none.

Ports:
- CLK  in  1  pipeline clock; all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- ihit  in  1  instruction cache returned imemload for current PC
- imemload  in  32  instruction word from instruction cache
- dhit  in  1  data cache completed the memory-stage request
- dREN_mem, dWEN_mem  in  1 each  memory-stage request
- halt_mem  in  1  halt instruction in memory stage
- redirect_mem  in  1  taken branch or jump resolved in memory stage
- dREN_ex  in  1  load in execute stage
- regWSEL_ex  in  5  execute-stage destination register
- rs_dec, rt_dec  in  5 each  decode-stage source registers
- uses_rt_dec  in  1  decode instruction reads rt
- fd_state, de_state, em_state, mw_state  out  pipe_state_t  latch commands
- instr_fet  out  32  instruction presented to fd latch
- pc_en  out  1  PC register update enable
- halted  out  1  processor halted

## Operation
- FSM states: RUN, MEMWAIT, HALT.
- The latch commands are combinational from the FSM state, the fetch-buffer flag `iready` and the inputs. The first matching rule applies:
  1. RST high or state HALT: all latches STALL; pc_en=0.
  2. Memory busy, i.e. (dREN_mem|dWEN_mem)&!dhit: fd, de, em STALL; mw FLUSH; pc_en=0.
  3. halt_mem with memory not busy: mw ENABLE; fd, de, em FLUSH; pc_en=0.
  4. redirect_mem: fd, de, em FLUSH; mw ENABLE; pc_en=1.
  5. Load-use: dREN_ex & regWSEL_ex!=0 & (regWSEL_ex==rs_dec | (uses_rt_dec & regWSEL_ex==rt_dec)). Commands: fd STALL; de FLUSH; em, mw ENABLE; pc_en=0.
  6. Fetch not ready, !ihit & !iready: fd FLUSH (bubble into decode); de, em, mw ENABLE; pc_en=0.
  7. Otherwise all ENABLE; pc_en=1.
- FSM transitions:
  - RUN -> MEMWAIT when rule 2 fires.
  - MEMWAIT -> RUN on dhit.
  - RUN/MEMWAIT -> HALT when rule 3 fires.
  - HALT is exited only by reset.
- Fetch buffer:
  - If ihit and fd_state!=ENABLE and !redirect_mem, capture imemload into `held` and set iready=1.
  - Clear iready when fd_state==ENABLE or redirect_mem.
  - instr_fet = iready ? held : imemload.
- halted = (state==HALT).

## Timing
- Reset values: state=RUN, iready=0, held=0. While RST is high, outputs are forced to all STALL, pc_en=0, halted=0, instr_fet=imemload.
- Latch commands have zero-cycle latency: combinational from current inputs and registered state.
- Data wait: the stall holds for every cycle dhit is low. On the dhit cycle the em->mw transfer happens (rule 2 is false), so the request is never reissued.
- Simultaneous events:
  - dhit together with redirect_mem applies rule 4 in the same cycle.
  - halt_mem with redirect_mem: halt wins.
  - Load-use with redirect_mem: redirect wins.
- Buffered fetch: an ihit during a stall is consumed on the first ENABLE cycle, even if ihit has dropped by then.
- halted rises one cycle after halt_mem is accepted; the halt reaches the mw latch on that edge.
- RST asserted mid-MEMWAIT returns the FSM to RUN and discards `held` immediately.

## Structure
- pipe_state_t (PIPE_ENABLE, PIPE_STALL, PIPE_FLUSH) lives in cpu_types_pkg.
- hazard_state_t (RUN, MEMWAIT, HALT) also lives in cpu_types_pkg.
- Sub-module fetch_buffer holds iready/held with inputs ihit, imemload, fd_advance, redirect and outputs iready, instr_fet.
- Priority logic and the FSM stay in hazard_unit.

## Test plan
- Load-use: dREN_ex=1, regWSEL_ex=5, rs_dec=5, ihit=1. Required: fd STALL, de FLUSH, em/mw ENABLE, pc_en=0. Also `held` captured, so instr_fet equals that word on the next ENABLE cycle with ihit=0.
- Data wait: dREN_mem=1, dhit low for 3 cycles then high. Required: 3 cycles of fd/de/em STALL with mw FLUSH, MEMWAIT for cycles 2–3, then all ENABLE on the dhit cycle and state RUN.
- Redirect during buffered fetch: iready=1, redirect_mem=1. Required: fd/de/em FLUSH, pc_en=1, iready=0 next cycle.
- Halt: halt_mem=1, dhit irrelevant (no request). Required: mw ENABLE with others FLUSH; halted=1 next cycle and held with all STALL for 10 cycles.
- Reset during MEMWAIT: assert RST asynchronously. Required: all STALL, pc_en=0 immediately; after release, state RUN and iready=0.
- I-miss: ihit=0 with no hazards. Required: fd FLUSH, de/em/mw ENABLE, pc_en=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: latch commands and hazard controller states.
package cpu_types_pkg;

   typedef enum logic [1:0] {
      PIPE_ENABLE = 2'd0,
      PIPE_STALL  = 2'd1,
      PIPE_FLUSH  = 2'd2
   } pipe_state_t;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MEMWAIT = 2'd1,
      HALT    = 2'd2
   } hazard_state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // Load in execute feeds a source operand of the decode instruction.
   function automatic logic load_use_hit(
      input logic       dren_ex,
      input logic [4:0] wsel_ex,
      input logic [4:0] rs,
      input logic [4:0] rt,
      input logic       uses_rt
   );
      return dren_ex && (wsel_ex != REG_ZERO) &&
             ((wsel_ex == rs) || (uses_rt && (wsel_ex == rt)));
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Holds an instruction returned by the I-cache while fetch cannot advance,
// so a hit during a stall is not lost.
module fetch_buffer
   import cpu_types_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        ihit,
   input  logic [31:0] imemload,
   input  logic        fd_advance,
   input  logic        redirect,
   output logic        iready,
   output logic [31:0] instr_fet
);

   logic        r_iready;
   logic [31:0] r_held;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_iready <= 1'b0;
         r_held   <= '0;
      end else if (ihit && !fd_advance && !redirect) begin
         r_iready <= 1'b1;
         r_held   <= imemload;
      end else if (fd_advance || redirect) begin
         r_iready <= 1'b0;
      end
   end

   assign iready    = r_iready;
   assign instr_fet = r_iready ? r_held : imemload;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: per-latch ENABLE/STALL/FLUSH and PC enable.
//   state   | meaning
//   RUN     | normal operation
//   MEMWAIT | memory-stage request outstanding, waiting for dhit
//   HALT    | halt retired, pipeline frozen until reset
module hazard_unit
   import cpu_types_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        ihit,
   input  logic [31:0] imemload,
   input  logic        dhit,
   input  logic        dREN_mem,
   input  logic        dWEN_mem,
   input  logic        halt_mem,
   input  logic        redirect_mem,
   input  logic        dREN_ex,
   input  logic [4:0]  regWSEL_ex,
   input  logic [4:0]  rs_dec,
   input  logic [4:0]  rt_dec,
   input  logic        uses_rt_dec,
   output pipe_state_t fd_state,
   output pipe_state_t de_state,
   output pipe_state_t em_state,
   output pipe_state_t mw_state,
   output logic [31:0] instr_fet,
   output logic        pc_en,
   output logic        halted
);

   hazard_state_t r_state;
   logic          w_mem_busy;
   logic          w_load_use;
   logic          w_iready;
   logic          w_fd_advance;

   assign w_mem_busy   = (dREN_mem || dWEN_mem) && !dhit;
   assign w_load_use   = load_use_hit(dREN_ex, regWSEL_ex, rs_dec, rt_dec, uses_rt_dec);
   assign w_fd_advance = (fd_state == PIPE_ENABLE);

   always_comb begin
      fd_state = PIPE_ENABLE;
      de_state = PIPE_ENABLE;
      em_state = PIPE_ENABLE;
      mw_state = PIPE_ENABLE;
      pc_en    = 1'b1;
      if (RST || (r_state == HALT)) begin
         fd_state = PIPE_STALL;
         de_state = PIPE_STALL;
         em_state = PIPE_STALL;
         mw_state = PIPE_STALL;
         pc_en    = 1'b0;
      end else if (w_mem_busy) begin
         fd_state = PIPE_STALL;
         de_state = PIPE_STALL;
         em_state = PIPE_STALL;
         mw_state = PIPE_FLUSH;
         pc_en    = 1'b0;
      end else if (halt_mem) begin
         fd_state = PIPE_FLUSH;
         de_state = PIPE_FLUSH;
         em_state = PIPE_FLUSH;
         pc_en    = 1'b0;
      end else if (redirect_mem) begin
         fd_state = PIPE_FLUSH;
         de_state = PIPE_FLUSH;
         em_state = PIPE_FLUSH;
      end else if (w_load_use) begin
         fd_state = PIPE_STALL;
         de_state = PIPE_FLUSH;
         pc_en    = 1'b0;
      end else if (!ihit && !w_iready) begin
         fd_state = PIPE_FLUSH;
         pc_en    = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= RUN;
      end else begin
         case (r_state)
            RUN: begin
               if (w_mem_busy)    r_state <= MEMWAIT;
               else if (halt_mem) r_state <= HALT;
            end
            MEMWAIT: begin
               if (halt_mem && !w_mem_busy) r_state <= HALT;
               else if (dhit)               r_state <= RUN;
            end
            HALT:    r_state <= HALT;
            default: r_state <= RUN;
         endcase
      end
   end

   assign halted = (r_state == HALT);

   fetch_buffer u_fetch_buffer (
      .CLK        (CLK),
      .RST        (RST),
      .ihit       (ihit),
      .imemload   (imemload),
      .fd_advance (w_fd_advance),
      .redirect   (redirect_mem),
      .iready     (w_iready),
      .instr_fet  (instr_fet)
   );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: driver queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_hazard_unit;
   import cpu_types_pkg::*;

   logic        CLK = 1'b0;
   logic        RST;
   logic        ihit;
   logic [31:0] imemload;
   logic        dhit, dREN_mem, dWEN_mem, halt_mem, redirect_mem, dREN_ex;
   logic [4:0]  regWSEL_ex, rs_dec, rt_dec;
   logic        uses_rt_dec;
   pipe_state_t fd_state, de_state, em_state, mw_state;
   logic [31:0] instr_fet;
   logic        pc_en, halted;

   localparam pipe_state_t E = PIPE_ENABLE;
   localparam pipe_state_t S = PIPE_STALL;
   localparam pipe_state_t F = PIPE_FLUSH;

   typedef struct {
      string       name;
      pipe_state_t fd, de, em, mw;
      logic        pc;
      logic        hl;
      logic [31:0] instr;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   bit   driver_done = 0;

   always #5 CLK = ~CLK;

   hazard_unit dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload), .dhit(dhit),
      .dREN_mem(dREN_mem), .dWEN_mem(dWEN_mem), .halt_mem(halt_mem),
      .redirect_mem(redirect_mem), .dREN_ex(dREN_ex), .regWSEL_ex(regWSEL_ex),
      .rs_dec(rs_dec), .rt_dec(rt_dec), .uses_rt_dec(uses_rt_dec),
      .fd_state(fd_state), .de_state(de_state), .em_state(em_state),
      .mw_state(mw_state), .instr_fet(instr_fet), .pc_en(pc_en), .halted(halted)
   );

   task automatic idle(input logic h, input logic [31:0] w);
      dhit = 0; dREN_mem = 0; dWEN_mem = 0; halt_mem = 0; redirect_mem = 0;
      dREN_ex = 0; regWSEL_ex = 0; rs_dec = 0; rt_dec = 0; uses_rt_dec = 0;
      ihit = h; imemload = w;
   endtask

   task automatic expect_cyc(input string nm, input pipe_state_t fd, input pipe_state_t de,
                             input pipe_state_t em, input pipe_state_t mw,
                             input logic pc, input logic hl, input logic [31:0] ins);
      exp_t e;
      e.name = nm; e.fd = fd; e.de = de; e.em = em; e.mw = mw;
      e.pc = pc; e.hl = hl; e.instr = ins;
      q.push_back(e);
      @(posedge CLK);
      #1;
   endtask

   // monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (q.size() > 0) begin
            e = q.pop_front();
            n_checks++;
            if (fd_state !== e.fd || de_state !== e.de || em_state !== e.em ||
                mw_state !== e.mw || pc_en !== e.pc || halted !== e.hl ||
                instr_fet !== e.instr) begin
               n_errors++;
               $display("FAIL %s: got fd=%0d de=%0d em=%0d mw=%0d pc_en=%0b halted=%0b instr=%h, want fd=%0d de=%0d em=%0d mw=%0d pc_en=%0b halted=%0b instr=%h",
                        e.name, fd_state, de_state, em_state, mw_state, pc_en, halted, instr_fet,
                        e.fd, e.de, e.em, e.mw, e.pc, e.hl, e.instr);
            end
         end
      end
   end

   // driver
   initial begin
      RST = 1'b1;
      idle(1, 32'hA000_0001);
      @(posedge CLK);
      #1;
      expect_cyc("reset", S, S, S, S, 0, 0, 32'hA000_0001);
      RST = 1'b0;

      idle(1, 32'hA000_0001);
      expect_cyc("normal", E, E, E, E, 1, 0, 32'hA000_0001);
      idle(0, 32'hB000_0002);
      expect_cyc("imiss", F, E, E, E, 0, 0, 32'hB000_0002);

      idle(1, 32'hC000_0003);
      dREN_ex = 1; regWSEL_ex = 5; rs_dec = 5;
      expect_cyc("loaduse_rs", S, F, E, E, 0, 0, 32'hC000_0003);
      idle(0, 32'hD000_0004);
      expect_cyc("buffered_consume", E, E, E, E, 1, 0, 32'hC000_0003);
      idle(0, 32'hE000_0005);
      expect_cyc("buffer_cleared", F, E, E, E, 0, 0, 32'hE000_0005);

      idle(1, 32'hF000_0006);
      dREN_ex = 1; regWSEL_ex = 7; rs_dec = 3; rt_dec = 7; uses_rt_dec = 1;
      expect_cyc("loaduse_rt", S, F, E, E, 0, 0, 32'hF000_0006);
      idle(1, 32'h1000_0007);
      dREN_ex = 1; regWSEL_ex = 7; rs_dec = 3; rt_dec = 7; uses_rt_dec = 0;
      expect_cyc("rt_unused", E, E, E, E, 1, 0, 32'hF000_0006);
      idle(1, 32'h1100_0008);
      dREN_ex = 1; regWSEL_ex = 0; rs_dec = 0;
      expect_cyc("r0_no_hazard", E, E, E, E, 1, 0, 32'h1100_0008);

      idle(1, 32'h2000_0009);
      dREN_mem = 1;
      expect_cyc("dwait_1", S, S, S, F, 0, 0, 32'h2000_0009);
      idle(0, 32'h2100_000A);
      dREN_mem = 1;
      expect_cyc("dwait_2", S, S, S, F, 0, 0, 32'h2000_0009);
      expect_cyc("dwait_3", S, S, S, F, 0, 0, 32'h2000_0009);
      dhit = 1;
      expect_cyc("dwait_hit", E, E, E, E, 1, 0, 32'h2000_0009);

      idle(0, 32'h3000_000B);
      dWEN_mem = 1;
      expect_cyc("store_wait", S, S, S, F, 0, 0, 32'h3000_000B);
      idle(1, 32'h3100_000C);
      dWEN_mem = 1; dhit = 1; redirect_mem = 1;
      expect_cyc("dhit_redirect", F, F, F, E, 1, 0, 32'h3100_000C);

      idle(1, 32'h4000_000D);
      dREN_ex = 1; regWSEL_ex = 9; rs_dec = 9;
      expect_cyc("loaduse_capture", S, F, E, E, 0, 0, 32'h4000_000D);
      idle(0, 32'h4100_000E);
      dREN_ex = 1; regWSEL_ex = 9; rs_dec = 9; redirect_mem = 1;
      expect_cyc("redirect_buffered", F, F, F, E, 1, 0, 32'h4000_000D);
      idle(0, 32'h4200_000F);
      expect_cyc("redirect_cleared", F, E, E, E, 0, 0, 32'h4200_000F);

      idle(1, 32'h5000_0010);
      dREN_mem = 1;
      expect_cyc("memwait_capture", S, S, S, F, 0, 0, 32'h5000_0010);
      idle(0, 32'h5100_0011);
      dREN_mem = 1;
      expect_cyc("memwait_held", S, S, S, F, 0, 0, 32'h5000_0010);
      RST = 1'b1;
      expect_cyc("reset_in_memwait", S, S, S, S, 0, 0, 32'h5100_0011);
      RST = 1'b0;
      idle(0, 32'h5200_0012);
      expect_cyc("post_reset", F, E, E, E, 0, 0, 32'h5200_0012);
      idle(1, 32'h5300_0013);
      expect_cyc("post_reset_run", E, E, E, E, 1, 0, 32'h5300_0013);

      idle(1, 32'h6000_0014);
      halt_mem = 1; redirect_mem = 1;
      expect_cyc("halt_accept", F, F, F, E, 0, 0, 32'h6000_0014);
      idle(1, 32'h6100_0015);
      for (int i = 0; i < 10; i++)
         expect_cyc("halted_hold", S, S, S, S, 0, 1, 32'h6100_0015);

      driver_done = 1;
   end

   // completion and watchdog
   initial begin
      int budget;
      budget = 2000;
      while (!(driver_done && q.size() == 0) && budget > 0) begin
         @(negedge CLK);
         budget--;
      end
      #1;
      if (!(driver_done && q.size() == 0)) begin
         n_checks++;
         n_errors++;
         $display("FAIL timeout: pending=%0d driver_done=%0b, want pending=0 driver_done=1",
                  q.size(), driver_done);
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
